// File: rtl/prio_enc_pkg.sv
// prio_enc_pkg: scan-mode type and width helper shared by the priority encoder blocks
package prio_enc_pkg;
  typedef enum logic {MODE_MSB, MODE_LSB} mode_e;
  function automatic int clog2_min1(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/prio_enc_pipe_if.sv
// prio_enc_pipe_if: valid/ready request and result channels of the pipelined priority encoder
interface prio_enc_pipe_if #(parameter int WIDTH = 8);
  import prio_enc_pkg::*;
  localparam int IDX_W = $clog2(WIDTH);
  logic in_valid;
  logic in_ready;
  logic [WIDTH-1:0] in_data;
  mode_e in_mode;
  logic out_valid;
  logic out_ready;
  logic [IDX_W-1:0] out_idx;
  logic out_found;
  modport master(output in_valid, in_data, in_mode, out_ready, input in_ready, out_valid, out_idx, out_found);
  modport slave(input in_valid, in_data, in_mode, out_ready, output in_ready, out_valid, out_idx, out_found);
endinterface

// File: rtl/prio_enc_group.sv
// prio_enc_group: combinational W-bit bit-scan; highest set bit in MSB mode, lowest in LSB mode
module prio_enc_group #(
  parameter int W = 4,
  localparam int LW = prio_enc_pkg::clog2_min1(W)
) (
  input  logic [W-1:0]          bits,
  input  prio_enc_pkg::mode_e   mode,
  output logic                  any,
  output logic [LW-1:0]         local_idx
);
  import prio_enc_pkg::*;
  assign any = |bits;
  // later matches overwrite earlier ones, so scan direction picks the winner
  always_comb begin
    local_idx = '0;
    for (int i = 0; i < W; i++) begin
      if (mode == MODE_MSB && bits[i]) local_idx = LW'(i);
      if (mode == MODE_LSB && bits[W-1-i]) local_idx = LW'(W-1-i);
    end
  end
endmodule

// File: rtl/prio_enc_pipe.sv
// prio_enc_pipe: 2-stage pipelined priority encoder; S1 scans groups, S2 picks the winning group
module prio_enc_pipe #(
  parameter int WIDTH = 8,
  parameter int GROUP_W = 4
) (
  input logic clock,
  input logic resetn,
  prio_enc_pipe_if.slave bus
);
  import prio_enc_pkg::*;
  localparam int IDX_W = $clog2(WIDTH);
  localparam int GROUPS = WIDTH / GROUP_W;
  localparam int LW = clog2_min1(GROUP_W);
  localparam int GW = clog2_min1(GROUPS);
  logic [GROUPS-1:0] g_any, s1_any;
  logic [LW-1:0] g_lidx [GROUPS];
  logic [LW-1:0] s1_lidx [GROUPS];
  mode_e s1_mode;
  logic s1_valid, s2_valid, rdy_q, s2_any, found_q, s1_load, s2_load;
  logic [GW-1:0] s2_grp;
  logic [IDX_W-1:0] idx_q;
  for (genvar g = 0; g < GROUPS; g++) begin : grp
    prio_enc_group #(.W(GROUP_W)) u_grp (
      .bits(bus.in_data[g*GROUP_W +: GROUP_W]),
      .mode(bus.in_mode),
      .any(g_any[g]),
      .local_idx(g_lidx[g])
    );
  end
  prio_enc_group #(.W(GROUPS)) u_sel (
    .bits(s1_any),
    .mode(s1_mode),
    .any(s2_any),
    .local_idx(s2_grp)
  );
  assign s2_load = !s2_valid || bus.out_ready;
  assign s1_load = !s1_valid || s2_load;
  // rdy_q keeps in_ready low until the first edge after reset release
  assign bus.in_ready = rdy_q && s1_load;
  assign bus.out_valid = s2_valid;
  assign bus.out_idx = idx_q;
  assign bus.out_found = found_q;
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rdy_q <= 1'b0;
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_any <= '0;
      s1_lidx <= '{default: '0};
      s1_mode <= MODE_MSB;
      idx_q <= '0;
      found_q <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (s1_load) begin
        s1_valid <= bus.in_valid && bus.in_ready;
        s1_any <= g_any;
        s1_lidx <= g_lidx;
        s1_mode <= bus.in_mode;
      end
      if (s2_load) begin
        s2_valid <= s1_valid;
        idx_q <= IDX_W'({s2_grp, s1_lidx[s2_grp]});
        found_q <= s2_any;
      end
    end
  end
endmodule

// File: tb/tb_prio_enc_pipe.sv
// tb_prio_enc_pipe: directed and random checks of 8-bit and 16-bit encoders against a bit-scan model
module tb_prio_enc_pipe;
  import prio_enc_pkg::*;
  logic clock = 1'b0;
  logic resetn = 1'b0;
  int tests = 0, fails = 0;
  int acc8 = 0, nout8 = 0, acc16 = 0, nout16 = 0;
  bit stall8 = 0, stall16 = 0, rnd = 0, s4done = 0;
  logic [4:0] q8[$];
  logic [4:0] q16[$];
  always #5 clock = ~clock;
  prio_enc_pipe_if #(.WIDTH(8)) b8();
  prio_enc_pipe_if #(.WIDTH(16)) b16();
  prio_enc_pipe #(.WIDTH(8), .GROUP_W(4)) dut8(.clock(clock), .resetn(resetn), .bus(b8.slave));
  prio_enc_pipe #(.WIDTH(16), .GROUP_W(4)) dut16(.clock(clock), .resetn(resetn), .bus(b16.slave));

  // {found, idx}: floor(log2) for MSB, log2 of the isolated lowest bit for LSB
  function automatic logic [4:0] ref_enc(logic [15:0] d, logic lsb);
    int unsigned v = d;
    int unsigned i;
    if (v == 0) return 5'd0;
    i = lsb ? $clog2(v & (~v + 1)) : $clog2(v + 1) - 1;
    return {1'b1, i[3:0]};
  endfunction

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic fail(string n);
    tests++;
    fails++;
    $display("FAIL %s: timed out", n);
  endtask

  task automatic send8(logic [7:0] d, mode_e m);
    b8.in_valid = 1'b1;
    b8.in_data = d;
    b8.in_mode = m;
    for (int k = 0; ; k++) begin
      @(posedge clock);
      if (b8.in_ready) break;
      if (k == 60) begin fail("accept8"); break; end
    end
    #1 b8.in_valid = 1'b0;
  endtask

  task automatic send16(logic [15:0] d, mode_e m);
    b16.in_valid = 1'b1;
    b16.in_data = d;
    b16.in_mode = m;
    for (int k = 0; ; k++) begin
      @(posedge clock);
      if (b16.in_ready) break;
      if (k == 60) begin fail("accept16"); break; end
    end
    #1 b16.in_valid = 1'b0;
  endtask

  task automatic lat8(logic [7:0] d, mode_e m, int ei, logic ef);
    send8(d, m);
    @(negedge clock);
    chk("lat8_early", b8.out_valid, 0);
    @(negedge clock);
    chk("lat8_valid", b8.out_valid, 1);
    chk("lat8_idx", b8.out_idx, ei);
    chk("lat8_found", b8.out_found, ef);
  endtask

  task automatic lat16(logic [15:0] d, mode_e m, int ei, logic ef);
    send16(d, m);
    @(negedge clock);
    chk("lat16_early", b16.out_valid, 0);
    @(negedge clock);
    chk("lat16_valid", b16.out_valid, 1);
    chk("lat16_idx", b16.out_idx, ei);
    chk("lat16_found", b16.out_found, ef);
  endtask

  always @(posedge clock) if (resetn) begin
    if (b8.in_valid && b8.in_ready) begin q8.push_back(ref_enc(16'(b8.in_data), b8.in_mode == MODE_LSB)); acc8++; end
    if (b8.out_valid && b8.out_ready) begin if (q8.size() != 0) void'(q8.pop_front()); nout8++; end
    stall8 = b8.out_valid && !b8.out_ready;
    if (b16.in_valid && b16.in_ready) begin q16.push_back(ref_enc(b16.in_data, b16.in_mode == MODE_LSB)); acc16++; end
    if (b16.out_valid && b16.out_ready) begin if (q16.size() != 0) void'(q16.pop_front()); nout16++; end
    stall16 = b16.out_valid && !b16.out_ready;
  end

  always @(negedge clock) if (resetn) begin
    if (stall8) chk("stall_valid8", b8.out_valid, 1);
    if (b8.out_valid) begin
      if (q8.size() == 0) chk("spurious8", q8.size(), 1);
      else begin
        chk("idx8", b8.out_idx, 32'(q8[0][3:0]));
        chk("found8", b8.out_found, q8[0][4]);
      end
    end
    if (stall16) chk("stall_valid16", b16.out_valid, 1);
    if (b16.out_valid) begin
      if (q16.size() == 0) chk("spurious16", q16.size(), 1);
      else begin
        chk("idx16", b16.out_idx, 32'(q16[0][3:0]));
        chk("found16", b16.out_found, q16[0][4]);
      end
    end
  end

  initial forever begin
    @(posedge clock);
    #1;
    if (rnd) begin
      b8.out_ready = $urandom_range(0, 3) != 0;
      b16.out_ready = $urandom_range(0, 2) != 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int o0, a0;
    logic [15:0] d;
    b8.in_valid = 0; b8.in_data = '0; b8.in_mode = MODE_MSB; b8.out_ready = 1;
    b16.in_valid = 0; b16.in_data = '0; b16.in_mode = MODE_MSB; b16.out_ready = 1;
    repeat (2) @(negedge clock);
    chk("rst_out_valid", b8.out_valid, 0);
    chk("rst_in_ready", b8.in_ready, 0);
    chk("rst_idx", b8.out_idx, 0);
    chk("rst_found", b8.out_found, 0);
    chk("rst_out_valid16", b16.out_valid, 0);
    resetn = 1'b1;
    @(posedge clock); #1;
    chk("rel_in_ready", b8.in_ready, 1);
    chk("model_msb", ref_enc(16'h002C, 0), 5'h15);
    chk("model_lsb", ref_enc(16'h002C, 1), 5'h12);
    chk("model_zero", ref_enc(16'h0000, 1), 5'h00);
    chk("model_8001", ref_enc(16'h8001, 0), 5'h1F);
    lat8(8'b0010_1100, MODE_MSB, 5, 1);
    lat8(8'b0010_1100, MODE_LSB, 2, 1);
    lat8(8'h00, MODE_MSB, 0, 0);
    lat8(8'h00, MODE_LSB, 0, 0);
    lat8(8'h80, MODE_LSB, 7, 1);
    lat8(8'h01, MODE_MSB, 0, 1);
    lat16(16'h8001, MODE_MSB, 15, 1);
    lat16(16'h8001, MODE_LSB, 0, 1);
    lat16(16'h0100, MODE_MSB, 8, 1);
    lat16(16'h0100, MODE_LSB, 8, 1);
    @(negedge clock);
    o0 = nout8;
    send8(8'h01, MODE_MSB); send8(8'h02, MODE_MSB); send8(8'h04, MODE_MSB); send8(8'h08, MODE_MSB);
    chk("stream_mid", nout8 - o0, 2);
    repeat (2) @(posedge clock);
    #1 chk("stream_end", nout8 - o0, 4);
    @(negedge clock);
    b8.out_ready = 0;
    a0 = acc8; o0 = nout8;
    fork
      begin send8(8'hF0, MODE_LSB); send8(8'h33, MODE_MSB); send8(8'h06, MODE_LSB); s4done = 1; end
    join_none
    repeat (4) begin @(posedge clock); #1; end
    chk("stall_accepts", acc8 - a0, 2);
    chk("stall_in_ready", b8.in_ready, 0);
    chk("stall_no_out", nout8 - o0, 0);
    b8.out_ready = 1;
    for (int k = 0; k < 30 && !(s4done && q8.size() == 0); k++) @(posedge clock);
    #1 chk("stall_drain", nout8 - o0, 3);
    @(negedge clock);
    b8.out_ready = 0;
    send8(8'hAA, MODE_MSB);
    send8(8'h55, MODE_LSB);
    @(negedge clock);
    resetn = 1'b0;
    #1;
    chk("flush_out_valid", b8.out_valid, 0);
    chk("flush_in_ready", b8.in_ready, 0);
    chk("flush_found", b8.out_found, 0);
    q8.delete(); q16.delete();
    stall8 = 0; stall16 = 0;
    @(negedge clock);
    resetn = 1'b1;
    b8.out_ready = 1;
    @(posedge clock); #1;
    chk("flush_rel_ready", b8.in_ready, 1);
    repeat (4) begin @(negedge clock); chk("flush_no_stale", b8.out_valid, 0); end
    rnd = 1;
    fork
      for (int n = 0; n < 200; n++) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
        d = 16'($urandom);
        if ($urandom_range(0, 7) == 0) d = 0;
        else if ($urandom_range(0, 3) == 0) d = 16'(1) << $urandom_range(0, 7);
        send8(d[7:0], mode_e'($urandom_range(0, 1)));
      end
      for (int n = 0; n < 200; n++) begin
        logic [15:0] e;
        repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
        e = 16'($urandom);
        if ($urandom_range(0, 7) == 0) e = 0;
        else if ($urandom_range(0, 3) == 0) e = 16'(1) << $urandom_range(0, 15);
        send16(e, mode_e'($urandom_range(0, 1)));
      end
    join
    rnd = 0;
    b8.out_ready = 1;
    b16.out_ready = 1;
    for (int k = 0; k < 100 && (q8.size() != 0 || q16.size() != 0); k++) @(posedge clock);
    #1;
    chk("drain8", q8.size(), 0);
    chk("drain16", q16.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
